text_cursor_ctrl: RTL and testbench

//  Write-side sequencer for the 32x32-cell text BRAM (5-bit glyph codes) that feeds the text renderer.

---
 rtl/text_cursor_ctrl_if.sv | 35 +++
 rtl/text_cursor_ctrl.sv | 217 +++++++++++++++++++++
 tb/tb_text_cursor_ctrl.sv | 306 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/text_cursor_ctrl_if.sv
// Token/BRAM-write bundle for text_cursor_ctrl.
// master: token producer / write observer side; slave: the sequencer itself.
interface text_cursor_ctrl_if #(
   parameter int COLS   = 32,
   parameter int ROWS   = 32,
   parameter int CODE_W = 5
);
   localparam int CW = $clog2(COLS);
   localparam int RW = $clog2(ROWS);
   localparam int AW = RW + CW;

   logic              tok_valid_in;
   logic [1:0]        tok_cmd_in;
   logic [CODE_W-1:0] tok_data_in;
   logic              tok_ready_out;
   logic              wr_en_out;
   logic [AW-1:0]     wr_addr_out;
   logic [CODE_W-1:0] wr_data_out;
   logic [RW-1:0]     cursor_row_out;
   logic [CW-1:0]     cursor_col_out;
   logic [RW-1:0]     scroll_out;
   logic              busy_out;

   modport master (
      output tok_valid_in, tok_cmd_in, tok_data_in,
      input  tok_ready_out, wr_en_out, wr_addr_out, wr_data_out,
      input  cursor_row_out, cursor_col_out, scroll_out, busy_out
   );

   modport slave (
      input  tok_valid_in, tok_cmd_in, tok_data_in,
      output tok_ready_out, wr_en_out, wr_addr_out, wr_data_out,
      output cursor_row_out, cursor_col_out, scroll_out, busy_out
   );
endinterface

// File: rtl/text_cursor_ctrl.sv
// text_cursor_ctrl: write-side sequencer for the ROWSxCOLS text BRAM.
// Consumes CHAR/NEWLINE/BACKSPACE/CLEAR tokens, tracks the cursor, issues
// one BRAM write per edge, blanks the buffer after reset / CLEAR and blanks
// each row as the cursor enters it.
// Build option: define TEXT_AUTOSCROLL_EN to get a live scroll_out that keeps
// the cursor row in the VIS_ROWS window; otherwise scroll_out is tied to 0.
module text_cursor_ctrl #(
   parameter int COLS       = 32,
   parameter int ROWS       = 32,
   parameter int VIS_ROWS   = 16,
   parameter int CODE_W     = 5,
   parameter int BLANK_CODE = 0
) (
   input  logic              clk_in,
   input  logic              rst_in,
   text_cursor_ctrl_if.slave bus
);
   localparam int CW = $clog2(COLS);
   localparam int RW = $clog2(ROWS);
   localparam int AW = RW + CW;

   localparam logic [1:0]        CMD_CHAR  = 2'd0;
   localparam logic [1:0]        CMD_NL    = 2'd1;
   localparam logic [1:0]        CMD_BS    = 2'd2;
   localparam logic [CW-1:0]     COL_LAST  = CW'(COLS - 1);
   localparam logic [RW-1:0]     ROW_LAST  = RW'(ROWS - 1);
   localparam logic [AW-1:0]     ADDR_LAST = AW'(ROWS * COLS - 1);
   localparam logic [CODE_W-1:0] BLANK     = CODE_W'(BLANK_CODE);

   // Geometry the address packing and scroll arithmetic rely on.
   if (VIS_ROWS < 1 || VIS_ROWS >= ROWS ||
       (COLS & (COLS - 1)) != 0 || (ROWS & (ROWS - 1)) != 0) begin : g_bad_cfg
      $error("text_cursor_ctrl: unsupported geometry");
   end

   typedef enum logic [1:0] {S_CLEAR = 2'd0, S_IDLE = 2'd1, S_LINE = 2'd2} state_t;

   state_t            r_state, w_state_n;
   logic [AW-1:0]     r_sweep, w_sweep_n;
   logic [CW-1:0]     r_lc, w_lc_n;
   logic [RW-1:0]     r_row, w_row_n;
   logic [CW-1:0]     r_col, w_col_n;
   logic              r_wr_en, w_wr_en_n;
   logic [AW-1:0]     r_wr_addr, w_wr_addr_n;
   logic [CODE_W-1:0] r_wr_data, w_wr_data_n;
   logic              w_accept;
   logic              w_sweep_last;
   logic [RW-1:0]     w_row_inc;
   logic [CW-1:0]     w_col_dec;

   assign w_accept     = bus.tok_valid_in && (r_state == S_IDLE);
   assign w_sweep_last = (r_state == S_CLEAR) && (r_sweep == ADDR_LAST);
   assign w_row_inc    = r_row + RW'(1);
   assign w_col_dec    = r_col - CW'(1);

   // State register; reset (re)starts the full-buffer blank sweep.
   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) r_state <= S_CLEAR;
      else        r_state <= w_state_n;
   end

   // Next state: sweeps run to their last cell, tokens only act in IDLE.
   always_comb begin
      w_state_n = r_state;
      case (r_state)
         S_CLEAR: if (r_sweep == ADDR_LAST) w_state_n = S_IDLE;
         S_IDLE: begin
            if (w_accept) begin
               case (bus.tok_cmd_in)
                  CMD_CHAR: if (r_col == COL_LAST) w_state_n = S_LINE;
                  CMD_NL:   w_state_n = S_LINE;
                  CMD_BS:   w_state_n = S_IDLE;
                  default:  w_state_n = S_CLEAR;
               endcase
            end
         end
         S_LINE:  if (r_lc == COL_LAST) w_state_n = S_IDLE;
         default: w_state_n = S_CLEAR;
      endcase
   end

   // Next write strobe, cursor and sweep counters.
   // NEWLINE and CLEAR issue their first blank on the accepting edge, so the
   // sweep counters start at 1; a CHAR that wraps spends its edge on the
   // glyph and starts the row blank at column 0 on the following edge.
   always_comb begin
      w_sweep_n   = r_sweep;
      w_lc_n      = r_lc;
      w_row_n     = r_row;
      w_col_n     = r_col;
      w_wr_en_n   = 1'b0;
      w_wr_addr_n = r_wr_addr;
      w_wr_data_n = r_wr_data;
      case (r_state)
         S_CLEAR: begin
            w_wr_en_n   = 1'b1;
            w_wr_addr_n = r_sweep;
            w_wr_data_n = BLANK;
            w_sweep_n   = r_sweep + AW'(1);
            if (w_sweep_last) begin
               w_row_n = '0;
               w_col_n = '0;
            end
         end
         S_IDLE: begin
            if (w_accept) begin
               case (bus.tok_cmd_in)
                  CMD_CHAR: begin
                     w_wr_en_n   = 1'b1;
                     w_wr_addr_n = {r_row, r_col};
                     w_wr_data_n = bus.tok_data_in;
                     if (r_col == COL_LAST) begin
                        w_col_n = '0;
                        w_row_n = w_row_inc;
                        w_lc_n  = '0;
                     end else begin
                        w_col_n = r_col + CW'(1);
                     end
                  end
                  CMD_NL: begin
                     w_col_n     = '0;
                     w_row_n     = w_row_inc;
                     w_wr_en_n   = 1'b1;
                     w_wr_addr_n = {w_row_inc, {CW{1'b0}}};
                     w_wr_data_n = BLANK;
                     w_lc_n      = CW'(1);
                  end
                  CMD_BS: begin
                     if (r_col != '0) begin
                        w_col_n     = w_col_dec;
                        w_wr_en_n   = 1'b1;
                        w_wr_addr_n = {r_row, w_col_dec};
                        w_wr_data_n = BLANK;
                     end
                  end
                  default: begin
                     w_wr_en_n   = 1'b1;
                     w_wr_addr_n = '0;
                     w_wr_data_n = BLANK;
                     w_sweep_n   = AW'(1);
                  end
               endcase
            end
         end
         S_LINE: begin
            w_wr_en_n   = 1'b1;
            w_wr_addr_n = {r_row, r_lc};
            w_wr_data_n = BLANK;
            w_lc_n      = r_lc + CW'(1);
         end
         default: ;
      endcase
   end

   // Datapath and output registers.
   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         r_sweep   <= '0;
         r_lc      <= '0;
         r_row     <= '0;
         r_col     <= '0;
         r_wr_en   <= 1'b0;
         r_wr_addr <= '0;
         r_wr_data <= '0;
      end else begin
         r_sweep   <= w_sweep_n;
         r_lc      <= w_lc_n;
         r_row     <= w_row_n;
         r_col     <= w_col_n;
         r_wr_en   <= w_wr_en_n;
         r_wr_addr <= w_wr_addr_n;
         r_wr_data <= w_wr_data_n;
      end
   end

`ifdef TEXT_AUTOSCROLL_EN
   logic          r_wrapped, w_wrapped_n;
   logic [RW-1:0] r_scroll, w_scroll_n;

   // Wrapped latches on the ROWS-1 -> 0 step and is cleared only when a full
   // blank sweep completes; scroll follows the next cursor row.
   always_comb begin
      w_wrapped_n = r_wrapped;
      if (w_sweep_last)
         w_wrapped_n = 1'b0;
      else if (r_row == ROW_LAST && w_row_n == '0)
         w_wrapped_n = 1'b1;
      if (!w_wrapped_n && w_row_n < RW'(VIS_ROWS))
         w_scroll_n = '0;
      else
         w_scroll_n = w_row_n - RW'(VIS_ROWS - 1);
   end

   // Scroll state registers.
   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         r_wrapped <= 1'b0;
         r_scroll  <= '0;
      end else begin
         r_wrapped <= w_wrapped_n;
         r_scroll  <= w_scroll_n;
      end
   end

   assign bus.scroll_out = r_scroll;
`else
   assign bus.scroll_out = '0;
`endif

   assign bus.tok_ready_out  = (r_state == S_IDLE);
   assign bus.busy_out       = (r_state != S_IDLE);
   assign bus.wr_en_out      = r_wr_en;
   assign bus.wr_addr_out    = r_wr_addr;
   assign bus.wr_data_out    = r_wr_data;
   assign bus.cursor_row_out = r_row;
   assign bus.cursor_col_out = r_col;
endmodule

// File: tb/tb_text_cursor_ctrl.sv
// Bench for text_cursor_ctrl: queue-based model of the pending BRAM writes
// checked every cycle, plus directed literal checks of the scenarios.
module tb_text_cursor_ctrl;
   localparam int COLS = 32, ROWS = 32, VIS = 16, CODE_W = 5, DEPTH = COLS * ROWS;
`ifdef TEXT_AUTOSCROLL_EN
   localparam bit AUTOSCROLL = 1'b1;
`else
   localparam bit AUTOSCROLL = 1'b0;
`endif

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   text_cursor_ctrl_if #(.COLS(COLS), .ROWS(ROWS), .CODE_W(CODE_W)) bus ();

   text_cursor_ctrl #(.COLS(COLS), .ROWS(ROWS), .VIS_ROWS(VIS), .CODE_W(CODE_W),
                      .BLANK_CODE(0)) dut (
      .clk_in (clk),
      .rst_in (rst),
      .bus    (bus)
   );

   typedef struct { int addr; int data; } wr_t;
   wr_t pend[$];
   wr_t wlog[$];
   int  m_row = 0, m_col = 0, m_addr = 0, m_data = 0;
   bit  m_wen = 0, m_wrapped = 0, m_clr = 0;
   int  n_checks = 0, n_err = 0;

   task automatic chk(string nm, int act, int exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
      end
   endtask

   function automatic int exp_scroll(int row, bit wrapped);
      if (!AUTOSCROLL || (!wrapped && row < VIS)) return 0;
      return (row - VIS + 1 + ROWS) % ROWS;
   endfunction

   task automatic push_wr(int a, int d);
      wr_t w;
      w.addr = a;
      w.data = d;
      pend.push_back(w);
   endtask

   task automatic adv_row();
      if (m_row == ROWS - 1) begin
         m_row = 0;
         m_wrapped = 1;
      end else m_row++;
   endtask

   task automatic blank_row();
      for (int c = 0; c < COLS; c++) push_wr(m_row * COLS + c, 0);
   endtask

   // Model: accepted tokens enqueue their writes; one write drains per edge.
   initial forever begin
      wr_t w;
      @(posedge clk or posedge rst);
      if (rst) begin
         pend.delete();
         for (int a = 0; a < DEPTH; a++) push_wr(a, 0);
         m_row = 0; m_col = 0; m_wen = 0; m_addr = 0; m_data = 0;
         m_wrapped = 0; m_clr = 1;
      end else begin
         if (bus.tok_valid_in && pend.size() == 0) begin
            case (bus.tok_cmd_in)
               2'd0: begin
                  push_wr(m_row * COLS + m_col, int'(bus.tok_data_in));
                  if (m_col == COLS - 1) begin
                     m_col = 0;
                     adv_row();
                     blank_row();
                  end else m_col++;
               end
               2'd1: begin
                  m_col = 0;
                  adv_row();
                  blank_row();
               end
               2'd2: begin
                  if (m_col > 0) begin
                     m_col--;
                     push_wr(m_row * COLS + m_col, 0);
                  end
               end
               default: begin
                  for (int a = 0; a < DEPTH; a++) push_wr(a, 0);
                  m_clr = 1;
               end
            endcase
         end
         if (pend.size() > 0) begin
            w = pend.pop_front();
            m_wen = 1; m_addr = w.addr; m_data = w.data;
            if (pend.size() == 0 && m_clr) begin
               m_clr = 0; m_row = 0; m_col = 0; m_wrapped = 0;
            end
         end else m_wen = 0;
      end
   end

   // Every-cycle compare against the model.
   initial forever begin
      @(negedge clk);
      chk("wr_en",  int'(bus.wr_en_out),      int'(m_wen));
      chk("wr_addr", int'(bus.wr_addr_out),   m_addr);
      chk("wr_data", int'(bus.wr_data_out),   m_data);
      chk("row",    int'(bus.cursor_row_out), m_row);
      chk("col",    int'(bus.cursor_col_out), m_col);
      chk("scroll", int'(bus.scroll_out),     exp_scroll(m_row, m_wrapped));
      chk("ready",  int'(bus.tok_ready_out),  int'(pend.size() == 0));
      chk("busy",   int'(bus.busy_out),       int'(pend.size() != 0));
   end

   // Write log for the directed checks.
   initial forever begin
      @(posedge clk);
      #1;
      if (bus.wr_en_out) begin
         wr_t w;
         w.addr = int'(bus.wr_addr_out);
         w.data = int'(bus.wr_data_out);
         wlog.push_back(w);
      end
   end

   task automatic wait_ready(int budget);
      int n = 0;
      while (!bus.tok_ready_out && n < budget) begin
         @(negedge clk);
         n++;
      end
      if (!bus.tok_ready_out) begin
         n_checks++; n_err++;
         $display("FAIL ready_timeout: ready=0 after %0d cycles, required 1", n);
      end
   endtask

   // Called at a negedge; returns at the negedge after the accepting edge.
   task automatic send(logic [1:0] cmd, int data);
      wait_ready(2000);
      bus.tok_valid_in = 1'b1;
      bus.tok_cmd_in   = cmd;
      bus.tok_data_in  = CODE_W'(data);
      @(posedge clk);
      @(negedge clk);
      bus.tok_valid_in = 1'b0;
      bus.tok_data_in  = CODE_W'(31);
   endtask

   task automatic count_until_ready(output int n);
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!bus.tok_ready_out && n < 2000);
   endtask

   task automatic chk_blanks(string nm, int first, int base, int cnt);
      int nbad = 0;
      for (int i = 0; i < cnt; i++)
         if (first + i >= wlog.size() || wlog[first + i].addr != base + i ||
             wlog[first + i].data != 0) nbad++;
      chk(nm, nbad, 0);
   endtask

   initial begin
      int n;
      bus.tok_valid_in = 1'b0;
      bus.tok_cmd_in   = 2'd0;
      bus.tok_data_in  = '0;
      repeat (3) @(negedge clk);
      chk("rst_busy",  int'(bus.busy_out), 1);
      chk("rst_ready", int'(bus.tok_ready_out), 0);
      chk("rst_wr_en", int'(bus.wr_en_out), 0);
      rst = 1'b0;

      // 1: power-up sweep
      count_until_ready(n);
      chk("t1_edges", n, 1024);
      chk("t1_nwrites", wlog.size(), 1024);
      chk_blanks("t1_sweep", 0, 0, 1024);
      chk("t1_row", int'(bus.cursor_row_out), 0);
      chk("t1_col", int'(bus.cursor_col_out), 0);

      // 2: two characters
      wlog.delete();
      send(2'd0, 5);
      send(2'd0, 7);
      chk("t2_nwrites", wlog.size(), 2);
      if (wlog.size() >= 2) begin
         chk("t2_addr0", wlog[0].addr, 0); chk("t2_data0", wlog[0].data, 5);
         chk("t2_addr1", wlog[1].addr, 1); chk("t2_data1", wlog[1].data, 7);
      end
      chk("t2_col", int'(bus.cursor_col_out), 2);

      // 3: fill row 0 to the wrap
      wlog.delete();
      for (int i = 2; i < 31; i++) send(2'd0, i);
      send(2'd0, 9);
      n = 0;
      while (!bus.tok_ready_out && n < 100) begin
         n++;
         @(negedge clk);
      end
      chk("t3_ready_low", n, 32);
      chk("t3_nwrites", wlog.size(), 62);
      if (wlog.size() >= 30) begin
         chk("t3_last_addr", wlog[29].addr, 31);
         chk("t3_last_data", wlog[29].data, 9);
      end
      chk_blanks("t3_row1_blank", 30, 32, 32);
      chk("t3_row", int'(bus.cursor_row_out), 1);
      chk("t3_col", int'(bus.cursor_col_out), 0);

      // 4: backspace
      send(2'd1, 0);
      send(2'd1, 0);
      for (int i = 1; i <= 4; i++) send(2'd0, i);
      wlog.delete();
      send(2'd2, 31);
      chk("t4_nwrites", wlog.size(), 1);
      if (wlog.size() >= 1) begin
         chk("t4_addr", wlog[0].addr, 99);
         chk("t4_data", wlog[0].data, 0);
      end
      chk("t4_col", int'(bus.cursor_col_out), 3);
      repeat (3) send(2'd2, 0);
      wlog.delete();
      send(2'd2, 0);
      @(negedge clk);
      chk("t4_bs0_nowrite", wlog.size(), 0);
      chk("t4_bs0_row", int'(bus.cursor_row_out), 3);
      chk("t4_bs0_col", int'(bus.cursor_col_out), 0);

      // 5: newlines and row wrap
      send(2'd3, 0);
      wait_ready(2000);
      chk("t5_clr_row", int'(bus.cursor_row_out), 0);
      chk("t5_clr_col", int'(bus.cursor_col_out), 0);
      repeat (20) send(2'd1, 0);
      wait_ready(100);
      chk("t5_row20", int'(bus.cursor_row_out), 20);
      chk("t5_scroll20", int'(bus.scroll_out), AUTOSCROLL ? 5 : 0);
      repeat (11) send(2'd1, 0);
      wait_ready(100);
      chk("t5_row31", int'(bus.cursor_row_out), 31);
      chk("t5_scroll31", int'(bus.scroll_out), AUTOSCROLL ? 16 : 0);
      wlog.delete();
      send(2'd1, 0);
      wait_ready(100);
      chk("t5_wrap_row", int'(bus.cursor_row_out), 0);
      chk("t5_wrap_scroll", int'(bus.scroll_out), AUTOSCROLL ? 17 : 0);
      chk("t5_wrap_nwrites", wlog.size(), 32);
      chk_blanks("t5_wrap_blank", 0, 0, 32);

      // 6: reset in the middle of a CLEAR sweep
      repeat (9) send(2'd1, 0);
      for (int i = 0; i < 9; i++) send(2'd0, i + 3);
      chk("t6_row9", int'(bus.cursor_row_out), 9);
      chk("t6_col9", int'(bus.cursor_col_out), 9);
      send(2'd3, 0);
      n = 0;
      while (int'(bus.wr_addr_out) != 500 && n < 2000) begin
         @(negedge clk);
         n++;
      end
      chk("t6_reach500", int'(bus.wr_addr_out), 500);
      chk("t6_mid_row", int'(bus.cursor_row_out), 9);
      #2 rst = 1'b1;
      #1;
      chk("t6_rst_wr_en",  int'(bus.wr_en_out), 0);
      chk("t6_rst_addr",   int'(bus.wr_addr_out), 0);
      chk("t6_rst_row",    int'(bus.cursor_row_out), 0);
      chk("t6_rst_col",    int'(bus.cursor_col_out), 0);
      chk("t6_rst_scroll", int'(bus.scroll_out), 0);
      chk("t6_rst_busy",   int'(bus.busy_out), 1);
      chk("t6_rst_ready",  int'(bus.tok_ready_out), 0);
      @(negedge clk);
      rst = 1'b0;
      wlog.delete();
      count_until_ready(n);
      chk("t6_edges", n, 1024);
      chk_blanks("t6_sweep", 0, 0, 1024);
      chk("t6_end_row", int'(bus.cursor_row_out), 0);
      chk("t6_end_col", int'(bus.cursor_col_out), 0);
      chk("t6_end_scroll", int'(bus.scroll_out), 0);

      @(negedge clk);
      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation still running at %0t, required to finish", $time);
      $fatal(1, "watchdog expired");
   end
endmodule
